guess_entry: RTL

//  Keypad-side producer for the game display controller. Collects three decimal

---
 rtl/guess_entry.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/guess_entry.sv
// guess_entry
//   Keypad-side producer for the game display controller. Buffers up to three
//   decimal digits from a debounced keypad and issues them as one guess with a
//   one-cycle ready strobe. After each issue the block stays busy for a short
//   hold window, and keys that arrive during that window are dropped.
//
// Ports
//   clk        in   1  system clock, rising edge
//   reset      in   1  asynchronous, active-low reset
//   key_code   in   4  0-9 digit, A=DEL, B=CLR, C=ENT, D-F ignored
//   key_valid  in   1  one-cycle key strobe
//   oNum1..3   out  4  issued digits (oNum1 = leftmost entered)
//   oNumRdy    out  1  one-cycle pulse: oNum1..3 carry a new guess
//   oCount     out  2  digits currently buffered (0..3)
//   oErr       out  1  one-cycle pulse: key rejected
//   busy       out  1  high while in ISSUE or HOLD
//
// Handshake: key_valid is a one-cycle strobe with no back-pressure. Keys seen
// while busy are discarded. oNumRdy is a one-cycle strobe, and the consumer
// must take oNum1..3 in that cycle. The values stay stable until the next issue.
module guess_entry #(
    parameter bit REQUIRE_DISTINCT = 1'b1,
    parameter int HOLD_CYCLES      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    output logic [3:0] oNum1,
    output logic [3:0] oNum2,
    output logic [3:0] oNum3,
    output logic       oNumRdy,
    output logic [1:0] oCount,
    output logic       oErr,
    output logic       busy
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);

    localparam logic [3:0] KEY_DEL = 4'hA;
    localparam logic [3:0] KEY_CLR = 4'hB;
    localparam logic [3:0] KEY_ENT = 4'hC;

    typedef enum logic [1:0] {
        ENTRY = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // state is kept as a named register so checkers can bind to it directly.
    state_t              state, state_n;
    logic [2:0][3:0]     slot, slot_n;
    logic [1:0]          count_n;
    logic [2:0][3:0]     num_n;
    logic [HW-1:0]       hold_cnt, hold_n;
    logic                err_n;
    logic                dup;

    assign dup = REQUIRE_DISTINCT &&
                 ((slot[0] == slot[1]) || (slot[0] == slot[2]) || (slot[1] == slot[2]));

    always_comb begin
        state_n = state;
        slot_n  = slot;
        count_n = oCount;
        num_n   = {oNum3, oNum2, oNum1};
        hold_n  = hold_cnt;
        err_n   = 1'b0;
        case (state)
            ENTRY: begin
                if (key_valid) begin
                    if (key_code <= 4'd9) begin
                        if (oCount != 2'd3) begin
                            slot_n[oCount] = key_code;
                            count_n        = oCount + 2'd1;
                        end else begin
                            err_n = 1'b1;
                        end
                    end else if (key_code == KEY_DEL) begin
                        if (oCount != 2'd0) begin
                            slot_n[oCount - 2'd1] = 4'd0;
                            count_n               = oCount - 2'd1;
                        end
                    end else if (key_code == KEY_CLR) begin
                        slot_n  = '0;
                        count_n = 2'd0;
                    end else if (key_code == KEY_ENT) begin
                        if ((oCount == 2'd3) && !dup) begin
                            num_n   = slot;
                            slot_n  = '0;
                            count_n = 2'd0;
                            state_n = ISSUE;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                    // D-F fall through with no effect
                end
            end
            ISSUE: begin
                state_n = HOLD;
                hold_n  = HOLD_INIT;
            end
            HOLD: begin
                if (hold_cnt == '0) begin
                    state_n = ENTRY;
                end else begin
                    hold_n = hold_cnt - 1'b1;
                end
            end
            default: state_n = ENTRY;
        endcase
    end

    // Strobes and busy are registered from the next state, so they line up
    // with the cycle in which the FSM actually sits in ISSUE/HOLD.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ENTRY;
            slot     <= '0;
            hold_cnt <= '0;
            oCount   <= 2'd0;
            oNum1    <= 4'd0;
            oNum2    <= 4'd0;
            oNum3    <= 4'd0;
            oNumRdy  <= 1'b0;
            oErr     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            slot     <= slot_n;
            hold_cnt <= hold_n;
            oCount   <= count_n;
            oNum1    <= num_n[0];
            oNum2    <= num_n[1];
            oNum3    <= num_n[2];
            oNumRdy  <= (state == ENTRY) && (state_n == ISSUE);
            oErr     <= err_n;
            busy     <= (state_n != ENTRY);
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (reset && key_valid) begin
            assert (!$isunknown(key_code))
                else $error("guess_entry: key_code unknown while key_valid");
        end
    end
`endif

endmodule
